// File: rtl/rand_num_gen_param_if.sv
// Request/result bundle between the controller side and the random number generator.
interface rand_num_gen_param_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LFSR_W = 16
);
  logic              req;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic [WIDTH-1:0]  range_max;
  logic [WIDTH-1:0]  rand_num;
  logic              rand_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output req, seed_load, seed_in, range_max,
    input  rand_num, rand_valid, busy, overrun
  );

  modport slave (
    input  req, seed_load, seed_in, range_max,
    output rand_num, rand_valid, busy, overrun
  );
endinterface

// File: rtl/rand_num_gen_param.sv
// Bounded random draws from a free-running Galois LFSR, triggered by a
// synchronised request edge; rejection sampling with a clamp fallback.
module rand_num_gen_param #(
  parameter int unsigned       WIDTH     = 4,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int unsigned       MAX_TRIES = 8
) (
  input logic                 clk,
  input logic                 rst,
  rand_num_gen_param_if.slave bus
);

  localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step_c;
  logic              s1_q, s2_q, s3_q;
  logic              req_edge_c;
  logic [WIDTH-1:0]  rmax_q;
  logic [WIDTH-1:0]  cand_c;
  logic [TRY_W-1:0]  try_cnt_q;
  logic [WIDTH-1:0]  rand_num_q;
  logic              rand_valid_q;
  logic              busy_q;
  logic              overrun_q;

  // Next LFSR value: a reseed overrides the step; a zero seed falls back to SEED
  always_comb begin
    lfsr_step_c = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    lfsr_d      = lfsr_step_c;
    if (bus.seed_load) begin
      lfsr_d = (bus.seed_in == '0) ? SEED : bus.seed_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Two-flop synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.req;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign req_edge_c = s2_q & ~s3_q;
  assign cand_c     = lfsr_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rmax_q       <= '0;
      try_cnt_q    <= '0;
      rand_num_q   <= '0;
      rand_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rand_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_edge_c) begin
            rmax_q    <= bus.range_max;
            try_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= DRAW;
          end
        end
        DRAW: begin
          // Requests arriving mid-draw are dropped, only flagged
          if (req_edge_c) begin
            overrun_q <= 1'b1;
          end
          if (cand_c <= rmax_q) begin
            rand_num_q   <= cand_c;
            rand_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else if (try_cnt_q == LAST_TRY) begin
            rand_num_q   <= rmax_q;
            rand_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            try_cnt_q <= try_cnt_q + TRY_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rand_num   = rand_num_q;
  assign bus.rand_valid = rand_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_rand_num_gen_param.sv
// Randomised self-checking bench for rand_num_gen_param against a
// draw-level reference model of the LFSR and rejection sampling.
module tb_rand_num_gen_param;

  localparam int MAX_TRIES = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] m_lfsr;

  typedef struct {
    int          pulses;
    int          pulse_cyc;
    int          exp_n;
    logic [3:0]  got;
    logic [3:0]  exp_val;
    logic        busy_at_pulse;
    logic [15:0] dut_l;
    logic [15:0] mdl_l;
  } draw_t;

  rand_num_gen_param_if #(.WIDTH(4), .LFSR_W(16)) bus ();

  rand_num_gen_param #(
    .WIDTH(4), .LFSR_W(16), .TAPS(16'hB400), .SEED(SEED), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR sequence tracked from the bench's own stimulus
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else if (bus.seed_load) m_lfsr <= (bus.seed_in == 16'h0) ? SEED : bus.seed_in;
    else m_lfsr <= step(m_lfsr);
  end

  // Draw outcome from the LFSR value at DRAW entry: first candidate within
  // bound wins; after MAX_TRIES rejections the bound itself is returned.
  function automatic int predict(input logic [15:0] l0, input logic [3:0] rmax,
                                 output logic [3:0] val);
    logic [15:0] l;
    l = l0;
    for (int k = 0; k < MAX_TRIES; k++) begin
      if (l[3:0] <= rmax) begin
        val = l[3:0];
        return k + 1;
      end
      l = step(l);
    end
    val = rmax;
    return MAX_TRIES;
  endfunction

  // Seed whose draw (entered three edges after loading) rejects every candidate at range 0
  function automatic logic [15:0] find_long_seed();
    logic [15:0] s;
    logic [3:0]  v;
    for (int i = 0; i < 4000; i++) begin
      s = 16'($urandom);
      if (s != 16'h0 && predict(step(step(step(s))), 4'h0, v) == MAX_TRIES) return s;
    end
    return 16'h0001;
  endfunction

  task automatic load_seed(input logic [15:0] s);
    bus.seed_load = 1'b1;
    bus.seed_in   = s;
    @(negedge clk);
    bus.seed_load = 1'b0;
    bus.seed_in   = 16'($urandom);
  endtask

  // Issues one request from a negedge and observes the resulting pulse(s)
  task automatic do_draw(input logic [3:0] rmax, output draw_t d);
    d.pulses = 0; d.pulse_cyc = -1; d.exp_n = 0; d.got = 4'h0; d.exp_val = 4'h0;
    d.busy_at_pulse = 1'b1; d.dut_l = 16'h0; d.mdl_l = 16'h0;
    bus.range_max = rmax;
    bus.req       = 1'b1;
    for (int cyc = 0; cyc < 2 + MAX_TRIES + 4; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        d.mdl_l = m_lfsr;
        d.dut_l = dut.lfsr_q;
        d.exp_n = predict(m_lfsr, rmax, d.exp_val);
        bus.range_max = 4'($urandom);
      end
      if (bus.rand_valid === 1'b1) begin
        d.pulses++;
        if (d.pulse_cyc < 0) begin
          d.pulse_cyc     = cyc;
          d.got           = bus.rand_num;
          d.busy_at_pulse = bus.busy;
        end
      end
    end
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (dut.lfsr_q !== 16'hACE1) begin n_fail++; $display("FAIL reset_lfsr: got %h expected ace1", dut.lfsr_q); end
    n_checks++; if ({bus.rand_num, bus.rand_valid, bus.busy, bus.overrun} !== 7'h0) begin n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {bus.rand_num, bus.rand_valid, bus.busy, bus.overrun}); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (dut.lfsr_q !== 16'hE270) begin n_fail++; $display("FAIL release_lfsr: got %h expected e270", dut.lfsr_q); end
    n_checks++; if ({bus.rand_num, bus.rand_valid, bus.busy, bus.overrun} !== 7'h0) begin n_fail++;
      $display("FAIL release_outputs: got %h expected 0", {bus.rand_num, bus.rand_valid, bus.busy, bus.overrun}); end
  endtask

  task automatic test_full_range();
    draw_t d;
    for (int i = 0; i < 3; i++) begin
      do_draw(4'hF, d);
      n_checks++; if (d.pulses !== 1) begin n_fail++; $display("FAIL full_pulses: got %0d expected 1", d.pulses); end
      n_checks++; if (d.pulse_cyc !== 3) begin n_fail++; $display("FAIL full_latency: got %0d expected 3", d.pulse_cyc); end
      n_checks++; if (d.got !== d.mdl_l[3:0]) begin n_fail++; $display("FAIL full_value: got %h expected %h", d.got, d.mdl_l[3:0]); end
      n_checks++; if (d.dut_l !== d.mdl_l) begin n_fail++; $display("FAIL full_lfsr: got %h expected %h", d.dut_l, d.mdl_l); end
    end
  endtask

  task automatic test_seed_sequence();
    draw_t d;
    load_seed(16'h0001);
    n_checks++; if (dut.lfsr_q !== 16'h0001) begin n_fail++; $display("FAIL seed_load: got %h expected 0001", dut.lfsr_q); end
    @(negedge clk);
    n_checks++; if (dut.lfsr_q !== 16'hB400) begin n_fail++; $display("FAIL seed_step1: got %h expected b400", dut.lfsr_q); end
    @(negedge clk);
    n_checks++; if (dut.lfsr_q !== 16'h5A00) begin n_fail++; $display("FAIL seed_step2: got %h expected 5a00", dut.lfsr_q); end
    for (int i = 0; i < 4; i++) begin
      do_draw(4'h7, d);
      n_checks++; if (d.got > 4'h7) begin n_fail++; $display("FAIL seed_bound: got %h expected <=7", d.got); end
      n_checks++; if (d.got !== d.exp_val) begin n_fail++; $display("FAIL seed_value: got %h expected %h", d.got, d.exp_val); end
      n_checks++; if (d.pulse_cyc !== 2 + d.exp_n) begin n_fail++; $display("FAIL seed_length: got %0d expected %0d", d.pulse_cyc, 2 + d.exp_n); end
    end
  endtask

  task automatic test_random_draws();
    draw_t      d;
    logic [3:0] rmax;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(3) == 0) load_seed(16'($urandom));
      rmax = 4'($urandom);
      do_draw(rmax, d);
      n_checks++; if (d.pulses !== 1) begin n_fail++; $display("FAIL rand_pulses: got %0d expected 1", d.pulses); end
      n_checks++; if (d.got !== d.exp_val) begin n_fail++; $display("FAIL rand_value: got %h expected %h (rmax %h)", d.got, d.exp_val, rmax); end
      n_checks++; if (d.pulse_cyc !== 2 + d.exp_n) begin n_fail++; $display("FAIL rand_length: got %0d expected %0d", d.pulse_cyc, 2 + d.exp_n); end
      n_checks++; if (d.busy_at_pulse !== 1'b0) begin n_fail++; $display("FAIL rand_busy: got %b expected 0", d.busy_at_pulse); end
      n_checks++; if (bus.rand_num !== d.exp_val) begin n_fail++; $display("FAIL rand_hold: got %h expected %h", bus.rand_num, d.exp_val); end
    end
  endtask

  task automatic test_zero_range();
    draw_t d;
    load_seed(find_long_seed());
    do_draw(4'h0, d);
    n_checks++; if (d.pulse_cyc !== 2 + MAX_TRIES) begin n_fail++; $display("FAIL zero_length: got %0d expected %0d", d.pulse_cyc, 2 + MAX_TRIES); end
    n_checks++; if (d.got !== 4'h0) begin n_fail++; $display("FAIL zero_value: got %h expected 0", d.got); end
    n_checks++; if (d.busy_at_pulse !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", d.busy_at_pulse); end
    load_seed(16'h0000);
    n_checks++; if (dut.lfsr_q !== 16'hACE1) begin n_fail++; $display("FAIL zero_seed: got %h expected ace1", dut.lfsr_q); end
  endtask

  task automatic test_overrun();
    int         pulses = 0;
    int         pulse_cyc = -1;
    logic [3:0] got = 4'hF;
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", bus.overrun); end
    load_seed(find_long_seed());
    bus.range_max = 4'h0;
    bus.req       = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.req = 1'b0;
      if (cyc == 2) bus.req = 1'b1;
      if (bus.rand_valid === 1'b1) begin
        pulses++;
        if (pulse_cyc < 0) begin pulse_cyc = cyc; got = bus.rand_num; end
      end
    end
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", pulses); end
    n_checks++; if (pulse_cyc !== 2 + MAX_TRIES) begin n_fail++; $display("FAIL overrun_length: got %0d expected %0d", pulse_cyc, 2 + MAX_TRIES); end
    n_checks++; if (got !== 4'h0) begin n_fail++; $display("FAIL overrun_value: got %h expected 0", got); end
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
  endtask

  task automatic test_hold_req();
    int pulses = 0;
    bus.range_max = 4'($urandom);
    bus.req       = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.rand_valid === 1'b1) pulses++;
    end
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL hold_pulses: got %0d expected 1", pulses); end
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL hold_overrun: got %b expected 1", bus.overrun); end
  endtask

  task automatic test_reset_mid_draw();
    draw_t d;
    int    pulses = 0;
    load_seed(find_long_seed());
    bus.range_max = 4'h0;
    bus.req       = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL middraw_busy: got %b expected 1", bus.busy); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({bus.busy, bus.rand_valid, bus.overrun} !== 3'b000) begin n_fail++;
      $display("FAIL async_reset: got %b expected 000", {bus.busy, bus.rand_valid, bus.overrun}); end
    n_checks++; if (dut.lfsr_q !== 16'hACE1) begin n_fail++; $display("FAIL async_lfsr: got %h expected ace1", dut.lfsr_q); end
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.rand_valid === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL post_reset_pulses: got %0d expected 0", pulses); end
    do_draw(4'($urandom), d);
    n_checks++; if (d.got !== d.exp_val) begin n_fail++; $display("FAIL post_reset_value: got %h expected %h", d.got, d.exp_val); end
    n_checks++; if (d.pulse_cyc !== 2 + d.exp_n) begin n_fail++; $display("FAIL post_reset_length: got %0d expected %0d", d.pulse_cyc, 2 + d.exp_n); end
  endtask

  initial begin
    bus.req       = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in   = 16'h0;
    bus.range_max = 4'h0;
    test_reset();
    test_full_range();
    test_seed_sequence();
    test_random_draws();
    test_zero_range();
    test_overrun();
    test_hold_req();
    test_reset_mid_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_num_gen_param.md
Name: rand_num_gen_param

Overview:
- Parametrised successor to the 4-bit button-driven random number generator.
- A free-running Galois LFSR is sampled on a synchronised, edge-detected request.
- Each draw returns a WIDTH-bit value bounded to 0..range_max using rejection sampling with a retry limit.
- Also provides runtime reseeding, a one-cycle valid strobe, busy status and a sticky overrun flag. Sits between the debounced button/controller logic and display/game logic.

Parameters:
- WIDTH, 4: output number width; must satisfy 1 <= WIDTH <= LFSR_W.
- LFSR_W, 16: LFSR state width.
- TAPS, 16'hB400: Galois feedback mask, LFSR_W bits wide.
- SEED, 16'hACE1: reset and fallback seed; must be non-zero.
- MAX_TRIES, 8: maximum candidates evaluated per draw before the clamp fallback is used.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  draw request; asynchronous level input; a rising edge starts a draw.
- seed_load  in  1  synchronous reseed strobe.
- seed_in  in  LFSR_W  new seed; a zero value loads SEED instead.
- range_max  in  WIDTH  inclusive upper bound; sampled on entry to DRAW.
- rand_num  out  WIDTH  last accepted number; held until the next accept.
- rand_valid  out  1  one-cycle pulse when rand_num updates.
- busy  out  1  high while in DRAW.
- overrun  out  1  sticky; set when a request edge is detected while busy.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - lfsr=SEED, rand_num=0, rand_valid=0, busy=0, overrun=0;
  - sync flops s1=s2=s3=0, try_cnt=0, state=IDLE.
- LFSR:
  - Advances on every clk edge when out of reset, in every state.
  - Step: lsb=lfsr[0]; lfsr=(lfsr>>1) ^ (lsb ? TAPS : 0).
  - seed_load=1 replaces the step that cycle with seed_in, or SEED if seed_in==0.
  - seed_load during DRAW is allowed; the draw continues using the new sequence.
  - All-zero state is unreachable.
- Request path:
  - req passes through s1, then s2 (two-flop synchroniser), then s3.
  - req_edge = s2 & ~s3; a held-high req yields exactly one edge.
- State IDLE:
  - req_edge=1: latch range_max into rmax_q, set try_cnt=0, go to DRAW, busy=1.
- State DRAW, each cycle, with cand = lfsr[WIDTH-1:0] (current register value):
  - cand <= rmax_q: rand_num<=cand, rand_valid<=1, go to IDLE.
  - Else if try_cnt==MAX_TRIES-1: rand_num<=rmax_q (clamp fallback), rand_valid<=1, go to IDLE.
  - Else: try_cnt<=try_cnt+1 and stay in DRAW; the LFSR has advanced, so the next cycle presents a fresh candidate.
  - req_edge in DRAW is dropped (no queueing) and sets overrun<=1.
- Latency:
  - Edge E0 first samples req=1; E1 sets s2; E2 enters DRAW; first accept at E3.
  - So rand_valid is high the cycle after E3; each rejection adds one cycle.
  - Worst case: E2+MAX_TRIES.
- rand_valid is high for exactly one cycle per draw and is never asserted in IDLE without a draw.
- rmax_q == 2^WIDTH-1: every candidate is accepted (single-cycle DRAW).
- rmax_q == 0: accept only cand==0; otherwise clamp to 0 after MAX_TRIES.
- range_max changes during DRAW: ignored until the next draw.
- Reset asserted mid-DRAW: immediate return to reset values; any partial draw is discarded.

Test Plan:
- Reset then release: lfsr holds 16'hACE1 during reset and reads 16'hE270 one edge after release; all outputs are 0.
- range_max=4'hF, single req pulse: rand_valid rises exactly 3 edges after the first sampling edge; rand_num equals lfsr[3:0] from the DRAW cycle (checked against a bench reference model); exactly one pulse.
- seed_load with seed_in=16'h0001, range_max=4'h7: the model predicts the sequence 0xB400, 0x5A00, ...; each accepted value is <=7; DRAW length equals rejections+1.
- range_max=0, seed chosen so the first MAX_TRIES candidates are non-zero: rand_num=0 after exactly 8 DRAW cycles, busy falls with rand_valid; seed_in=0 loads 16'hACE1.
- Second req edge while busy: ignored, overrun=1 and held until rst; req held high for 500 ns produces a single draw.
- rst pulled low mid-DRAW: busy=0 and rand_valid=0 immediately (asynchronous); no rand_valid after release until a new req edge.
